// File: rtl/raxi_rx_buffer.sv
// raxi_rx_buffer: rAXI valid/data receiver with FIFO storage (DEPTH-1 entry RAM plus output register)
// and sticky overflow flag; optional word/drop statistics under RAXI_RX_BUFFER_STATS_EN.
`default_nettype none

module raxi_rx_buffer #(
  parameter int DATA_WIDTH  = 10,
  parameter int DEPTH       = 16,
  parameter int AFULL_LEVEL = 12
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    i_valid,
  input  logic [DATA_WIDTH-1:0]   i_data,
  output logic                    o_valid,
  output logic [DATA_WIDTH-1:0]   o_data,
  input  logic                    i_ready,
  output logic [$clog2(DEPTH):0]  o_count,
  output logic                    o_afull,
  output logic                    o_overflow,
`ifdef RAXI_RX_BUFFER_STATS_EN
  output logic [31:0]             o_rx_cnt,
  output logic [15:0]             o_drop_cnt,
`endif
  input  logic                    i_clear_ovf
);

  localparam int CW        = $clog2(DEPTH) + 1;
  localparam int PW        = $clog2(DEPTH);
  localparam int RAM_DEPTH = DEPTH - 1;

  typedef enum logic {
    EMPTY = 1'b0,
    HOLD  = 1'b1
  } state_t;

  state_t                  state, state_nxt;
  logic [DATA_WIDTH-1:0]   mem [RAM_DEPTH];
  logic [PW-1:0]           wr_ptr, rd_ptr;
  logic [CW-1:0]           count_nxt;
  logic [DATA_WIDTH-1:0]   data_nxt;
  logic                    full, pop, push, drop;
  logic                    ram_has, load_out, ram_rd, bypass, ram_wr;

  // RAM pointers wrap modulo DEPTH-1, which need not be a power of two.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(RAM_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign o_valid = (state == HOLD);

  always_comb begin
    full      = (o_count == CW'(DEPTH));
    pop       = o_valid && i_ready;
    push      = i_valid && (!full || pop);
    drop      = i_valid && !push;
    ram_has   = (o_count > CW'(o_valid));
    load_out  = !o_valid || pop;
    ram_rd    = load_out && ram_has;
    bypass    = load_out && !ram_has && push;
    ram_wr    = push && !bypass;
    count_nxt = o_count + CW'(push) - CW'(pop);
  end

  // RAM head has priority over the incoming word to keep ordering.
  always_comb begin
    state_nxt = state;
    data_nxt  = o_data;
    if (ram_rd) begin
      state_nxt = HOLD;
      data_nxt  = mem[rd_ptr];
    end else if (bypass) begin
      state_nxt = HOLD;
      data_nxt  = i_data;
    end else if (pop) begin
      state_nxt = EMPTY;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= EMPTY;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      o_data     <= '0;
      o_count    <= '0;
      o_afull    <= 1'b0;
      o_overflow <= 1'b0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
    end else begin
      o_data  <= data_nxt;
      o_count <= count_nxt;
      o_afull <= (count_nxt >= CW'(AFULL_LEVEL));
      if (ram_wr) wr_ptr <= ptr_inc(wr_ptr);
      if (ram_rd) rd_ptr <= ptr_inc(rd_ptr);
      if (drop)             o_overflow <= 1'b1;
      else if (i_clear_ovf) o_overflow <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (ram_wr) mem[wr_ptr] <= i_data;
  end

`ifdef RAXI_RX_BUFFER_STATS_EN
  // A clear coinciding with an event restarts the counter at one.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      o_rx_cnt   <= '0;
      o_drop_cnt <= '0;
    end else begin
      if (i_clear_ovf)  o_rx_cnt <= push ? 32'd1 : 32'd0;
      else if (push)    o_rx_cnt <= o_rx_cnt + 32'd1;
      if (i_clear_ovf)  o_drop_cnt <= drop ? 16'd1 : 16'd0;
      else if (drop && (o_drop_cnt != 16'hFFFF)) o_drop_cnt <= o_drop_cnt + 16'd1;
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_raxi_rx_buffer.sv
// tb_raxi_rx_buffer: scoreboard-driven bench for raxi_rx_buffer (default build, optional stats checks).
`default_nettype none
`timescale 1ns/1ps

module tb_raxi_rx_buffer;

  localparam int DW    = 10;
  localparam int DEPTH = 16;
  localparam int AFL   = 12;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rstn;
  logic          i_valid, i_ready, i_clear_ovf;
  logic [DW-1:0] i_data;
  logic          o_valid, o_afull, o_overflow;
  logic [DW-1:0] o_data;
  logic [CW-1:0] o_count;
`ifdef RAXI_RX_BUFFER_STATS_EN
  logic [31:0]   o_rx_cnt;
  logic [15:0]   o_drop_cnt;
`endif

  raxi_rx_buffer #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .AFULL_LEVEL(AFL)) dut (
    .clk(clk), .rstn(rstn),
    .i_valid(i_valid), .i_data(i_data),
    .o_valid(o_valid), .o_data(o_data), .i_ready(i_ready),
    .o_count(o_count), .o_afull(o_afull), .o_overflow(o_overflow),
`ifdef RAXI_RX_BUFFER_STATS_EN
    .o_rx_cnt(o_rx_cnt), .o_drop_cnt(o_drop_cnt),
`endif
    .i_clear_ovf(i_clear_ovf)
  );

  always #5 clk = ~clk;

  int            vectors = 0;
  int            miscompares = 0;
  logic [DW-1:0] sb[$];
  int            m_count = 0;
  logic          m_ovf = 1'b0;
  logic [31:0]   m_rx = '0;
  logic [15:0]   m_drop = '0;

  task automatic model_reset();
    sb.delete();
    m_count = 0;
    m_ovf   = 1'b0;
    m_rx    = '0;
    m_drop  = '0;
  endtask

  // Applies one cycle of stimulus; popped words are checked against the scoreboard.
  task automatic drive_cycle(input logic v, input logic [DW-1:0] d, input logic rdy, input logic clr);
    logic pop, push, drop;
    logic [DW-1:0] exp;
    i_valid = v; i_data = d; i_ready = rdy; i_clear_ovf = clr;
    pop  = (m_count > 0) && rdy;
    push = v && ((m_count < DEPTH) || pop);
    drop = v && !push;
    if (pop) begin
      exp = sb.pop_front();
      vectors++;
      if (o_valid !== 1'b1 || o_data !== exp) begin
        miscompares++;
        $display("FAIL pop_data: got valid=%0b data=%h, expected valid=1 data=%h", o_valid, o_data, exp);
      end
    end
    if (push) sb.push_back(d);
    m_count = m_count + int'(push) - int'(pop);
    if (drop) m_ovf = 1'b1;
    else if (clr) m_ovf = 1'b0;
    if (clr) m_rx = push ? 32'd1 : 32'd0;
    else if (push) m_rx = m_rx + 32'd1;
    if (clr) m_drop = drop ? 16'd1 : 16'd0;
    else if (drop && m_drop != 16'hFFFF) m_drop = m_drop + 16'd1;
    @(posedge clk);
    #1;
    i_clear_ovf = 1'b0;
  endtask

  task automatic test_reset();
    rstn = 1'b0; i_valid = 1'b0; i_data = '0; i_ready = 1'b0; i_clear_ovf = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if ({o_valid, o_data, o_count, o_afull, o_overflow} !== '0) begin
      miscompares++;
      $display("FAIL reset_values: got valid=%0b data=%h count=%0d afull=%0b ovf=%0b, expected all 0",
               o_valid, o_data, o_count, o_afull, o_overflow);
    end
    rstn = 1'b1;
  endtask

  task automatic test_bypass();
    for (int i = 1; i <= 5; i++) begin
      drive_cycle(1'b1, DW'(i), 1'b1, 1'b0);
      vectors++;
      if (o_valid !== 1'b1 || o_data !== DW'(i) || o_count !== CW'(1)) begin
        miscompares++;
        $display("FAIL bypass_%0d: got valid=%0b data=%h count=%0d, expected valid=1 data=%h count=1",
                 i, o_valid, o_data, o_count, DW'(i));
      end
    end
    drive_cycle(1'b0, '0, 1'b1, 1'b0);
    vectors++;
    if (o_valid !== 1'b0 || o_count !== CW'(0)) begin
      miscompares++;
      $display("FAIL bypass_empty: got valid=%0b count=%0d, expected valid=0 count=0", o_valid, o_count);
    end
  endtask

  task automatic test_fill();
    for (int i = 0; i < DEPTH; i++) begin
      drive_cycle(1'b1, DW'($urandom), 1'b0, 1'b0);
      vectors++;
      if (o_afull !== (i + 1 >= AFL) || o_count !== CW'(i + 1)) begin
        miscompares++;
        $display("FAIL fill_%0d: got afull=%0b count=%0d, expected afull=%0b count=%0d",
                 i, o_afull, o_count, (i + 1 >= AFL), i + 1);
      end
    end
    vectors++;
    if (o_overflow !== 1'b0) begin
      miscompares++;
      $display("FAIL fill_ovf: got %0b, expected 0", o_overflow);
    end
  endtask

  task automatic test_overflow();
    drive_cycle(1'b1, 10'h3AA, 1'b0, 1'b0);
    vectors++;
    if (o_overflow !== 1'b1 || o_count !== CW'(DEPTH)) begin
      miscompares++;
      $display("FAIL overflow: got ovf=%0b count=%0d, expected ovf=1 count=%0d", o_overflow, o_count, DEPTH);
    end
`ifdef RAXI_RX_BUFFER_STATS_EN
    vectors++;
    if (o_drop_cnt !== 16'd1) begin
      miscompares++;
      $display("FAIL overflow_drop_cnt: got %0d, expected 1", o_drop_cnt);
    end
`endif
  endtask

  task automatic test_clear_race();
    drive_cycle(1'b1, 10'h2BB, 1'b0, 1'b1);
    vectors++;
    if (o_overflow !== 1'b1) begin
      miscompares++;
      $display("FAIL clear_race: got ovf=%0b, expected 1", o_overflow);
    end
`ifdef RAXI_RX_BUFFER_STATS_EN
    vectors++;
    if (o_drop_cnt !== 16'd1 || o_rx_cnt !== 32'd0) begin
      miscompares++;
      $display("FAIL clear_race_stats: got drop=%0d rx=%0d, expected drop=1 rx=0", o_drop_cnt, o_rx_cnt);
    end
`endif
    drive_cycle(1'b0, '0, 1'b0, 1'b1);
    vectors++;
    if (o_overflow !== 1'b0 || o_count !== CW'(DEPTH)) begin
      miscompares++;
      $display("FAIL clear_alone: got ovf=%0b count=%0d, expected ovf=0 count=%0d", o_overflow, o_count, DEPTH);
    end
  endtask

  task automatic test_push_pop_full();
    drive_cycle(1'b1, 10'h155, 1'b1, 1'b0);
    vectors++;
    if (o_overflow !== 1'b0 || o_count !== CW'(DEPTH)) begin
      miscompares++;
      $display("FAIL push_pop_full: got ovf=%0b count=%0d, expected ovf=0 count=%0d", o_overflow, o_count, DEPTH);
    end
    vectors++;
    if (sb[DEPTH-1] !== 10'h155) begin
      miscompares++;
      $display("FAIL push_pop_order: scoreboard tail %h, expected 155", sb[DEPTH-1]);
    end
    for (int i = 0; i < DEPTH; i++) begin
      drive_cycle(1'b0, '0, 1'b1, 1'b0);
      vectors++;
      if (o_count !== CW'(DEPTH - 1 - i)) begin
        miscompares++;
        $display("FAIL drain_%0d: got count=%0d, expected %0d", i, o_count, DEPTH - 1 - i);
      end
    end
    vectors++;
    if (o_valid !== 1'b0 || o_afull !== 1'b0) begin
      miscompares++;
      $display("FAIL drain_empty: got valid=%0b afull=%0b, expected 0 0", o_valid, o_afull);
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 7; i++) drive_cycle(1'b1, DW'(10'h040 + i), 1'b0, 1'b0);
    vectors++;
    if (o_count !== CW'(7)) begin
      miscompares++;
      $display("FAIL mid_fill: got count=%0d, expected 7", o_count);
    end
    i_valid = 1'b0;
    #2 rstn = 1'b0;
    #1;
    model_reset();
    vectors++;
    if ({o_valid, o_data, o_count, o_afull, o_overflow} !== '0) begin
      miscompares++;
      $display("FAIL mid_reset: got valid=%0b data=%h count=%0d afull=%0b ovf=%0b, expected all 0",
               o_valid, o_data, o_count, o_afull, o_overflow);
    end
    @(posedge clk);
    #1 rstn = 1'b1;
    drive_cycle(1'b1, 10'h0FF, 1'b0, 1'b0);
    vectors++;
    if (o_valid !== 1'b1 || o_data !== 10'h0FF || o_count !== CW'(1)) begin
      miscompares++;
      $display("FAIL post_reset: got valid=%0b data=%h count=%0d, expected valid=1 data=0ff count=1",
               o_valid, o_data, o_count);
    end
    drive_cycle(1'b0, '0, 1'b1, 1'b0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      drive_cycle($urandom_range(0, 3) != 0, DW'($urandom), 1'($urandom_range(0, 1)),
                  $urandom_range(0, 15) == 0);
      vectors++;
      if (o_count !== CW'(m_count) || o_afull !== (m_count >= AFL) || o_overflow !== m_ovf) begin
        miscompares++;
        $display("FAIL random_%0d: got count=%0d afull=%0b ovf=%0b, expected count=%0d afull=%0b ovf=%0b",
                 i, o_count, o_afull, o_overflow, m_count, (m_count >= AFL), m_ovf);
      end
`ifdef RAXI_RX_BUFFER_STATS_EN
      vectors++;
      if (o_rx_cnt !== m_rx || o_drop_cnt !== m_drop) begin
        miscompares++;
        $display("FAIL random_stats_%0d: got rx=%0d drop=%0d, expected rx=%0d drop=%0d",
                 i, o_rx_cnt, o_drop_cnt, m_rx, m_drop);
      end
`endif
    end
    for (int i = 0; i <= DEPTH; i++) drive_cycle(1'b0, '0, 1'b1, 1'b0);
    vectors++;
    if (o_count !== CW'(0) || o_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL random_drain: got count=%0d valid=%0b, expected 0 0", o_count, o_valid);
    end
  endtask

  initial begin
    test_reset();
    test_bypass();
    test_fill();
    test_overflow();
    test_clear_race();
    test_push_pop_full();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
